// File: rtl/convolve_fpga_pkg.sv
// convolve_fpga_pkg: width helpers, stage tag bundle and lane slice macro
// shared by the convolve_fpga MAC pipe and its lanes.
package convolve_fpga_pkg;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } mac_tag_t;

   function automatic int full_w(input int a_w, input int b_w);
      return a_w + b_w + 2;
   endfunction

   function automatic int acc_w(input int a_w, input int b_w, input int guard);
      return full_w(a_w, b_w) + guard;
   endfunction

   function automatic logic ext_bit(input logic msb, input logic is_signed);
      return msb & is_signed;
   endfunction

endpackage

`define CONVOLVE_LANE(v, i, w) v[(i)*(w) +: (w)]

// File: rtl/convolve_fpga_mac_lane.sv
// convolve_fpga_mac_lane: one lane - operand regs, product, delay line, accumulator, format.
// Define CONVOLVE_MAC_SAT_EN to clamp results to signed P_W and raise ovf.
module convolve_fpga_mac_lane
   import convolve_fpga_pkg::*;
#(
   parameter int A_W       = 8,
   parameter int B_W       = 16,
   parameter int A_SIGNED  = 0,
   parameter int B_SIGNED  = 1,
   parameter int P_W       = 16,
   parameter int STAGES    = 4,
   parameter int ACC_GUARD = 4,
   parameter int SHIFT     = 0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           advance,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   input  logic           fin_valid,
   input  logic           fin_first,
   input  logic           fin_last,
   output logic [P_W-1:0] p,
   output logic           ovf
);

   localparam int FW  = full_w(A_W, B_W);
   localparam int AW  = acc_w(A_W, B_W, ACC_GUARD);
   localparam int RW  = AW + 1;
   localparam int NPQ = STAGES - 2;
   localparam logic signed [RW-1:0] RND =
      (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   logic [A_W-1:0]        a_q;
   logic [B_W-1:0]        b_q;
   logic signed [A_W:0]   a_x;
   logic signed [B_W:0]   b_x;
   logic signed [FW-1:0]  prod_q [NPQ];
   logic signed [AW-1:0]  acc_q;
   logic signed [AW-1:0]  sum;
   logic signed [RW-1:0]  rnd_sum;
   logic signed [RW-1:0]  r;
   logic [P_W-1:0]        p_d;
   logic                  ovf_d;

   assign a_x = {ext_bit(a_q[A_W-1], A_SIGNED != 0), a_q};
   assign b_x = {ext_bit(b_q[B_W-1], B_SIGNED != 0), b_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
         for (int i = 0; i < NPQ; i++) prod_q[i] <= '0;
      end else if (advance) begin
         a_q       <= a;
         b_q       <= b;
         prod_q[0] <= FW'(a_x) * FW'(b_x);
         for (int i = 1; i < NPQ; i++) prod_q[i] <= prod_q[i-1];
      end
   end

   // Rounding add is one bit wider so it cannot wrap the accumulated sum.
   always_comb begin
      sum     = (fin_first ? '0 : acc_q) + AW'(prod_q[NPQ-1]);
      rnd_sum = RW'(sum) + RND;
      r       = rnd_sum >>> SHIFT;
   end

`ifdef CONVOLVE_MAC_SAT_EN
   logic [RW-P_W:0] hi;

   assign hi = r[RW-1:P_W-1];

   always_comb begin
      ovf_d = ~((&hi) | ~(|hi));
      p_d   = P_W'(r);
      if (ovf_d)
         p_d = hi[RW-P_W] ? {1'b1, {(P_W-1){1'b0}}}
                          : {1'b0, {(P_W-1){1'b1}}};
   end
`else
   assign p_d   = P_W'(r);
   assign ovf_d = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         p     <= '0;
         ovf   <= 1'b0;
      end else if (advance && fin_valid) begin
         if (fin_last) begin
            acc_q <= '0;
            p     <= p_d;
            ovf   <= ovf_d;
         end else begin
            acc_q <= sum;
         end
      end
   end

endmodule

// File: rtl/convolve_fpga_mac_pipe.sv
// convolve_fpga_mac_pipe: LANES-wide MAC pipe with valid/ready, packet accumulation and rounding.
// Define CONVOLVE_MAC_SAT_EN for saturating output and per-lane out_ovf.
module convolve_fpga_mac_pipe
   import convolve_fpga_pkg::*;
#(
   parameter int LANES     = 1,
   parameter int A_W       = 8,
   parameter int B_W       = 16,
   parameter int A_SIGNED  = 0,
   parameter int B_SIGNED  = 1,
   parameter int P_W       = 16,
   parameter int STAGES    = 4,
   parameter int ACC_GUARD = 4,
   parameter int SHIFT     = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [LANES*A_W-1:0] in_a,
   input  logic [LANES*B_W-1:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*P_W-1:0] out_p,
   output logic [LANES-1:0]     out_ovf
);

   localparam int NT = STAGES - 1;

   logic     advance;
   mac_tag_t tag_q [NT];
   mac_tag_t fin;

   // The whole pipe stalls together while a result waits downstream.
   assign advance  = ce & (~out_valid | out_ready) & ~reset;
   assign in_ready = advance;
   assign fin      = tag_q[NT-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NT; i++) tag_q[i] <= '0;
         out_valid <= 1'b0;
      end else if (advance) begin
         tag_q[0] <= '{valid: in_valid, first: in_first, last: in_last};
         for (int i = 1; i < NT; i++) tag_q[i] <= tag_q[i-1];
         out_valid <= fin.valid & fin.last;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      convolve_fpga_mac_lane #(
         .A_W       (A_W),
         .B_W       (B_W),
         .A_SIGNED  (A_SIGNED),
         .B_SIGNED  (B_SIGNED),
         .P_W       (P_W),
         .STAGES    (STAGES),
         .ACC_GUARD (ACC_GUARD),
         .SHIFT     (SHIFT)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .advance   (advance),
         .a         (`CONVOLVE_LANE(in_a, i, A_W)),
         .b         (`CONVOLVE_LANE(in_b, i, B_W)),
         .fin_valid (fin.valid),
         .fin_first (fin.first),
         .fin_last  (fin.last),
         .p         (`CONVOLVE_LANE(out_p, i, P_W)),
         .ovf       (out_ovf[i])
      );
   end

endmodule
